// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit, also imported by the decoder
// and the hazard unit.
package mdu_defs;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MDU_CNT_W = 4;

endpackage

// File: rtl/mdu.sv
// MIPS multiply/divide unit: fixed-latency mult/div into private HI/LO,
// single-edge mthi/mtlo, busy for the hazard unit to stall on.
module mdu
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [MDU_CNT_W-1:0] MULT_N = MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] DIV_N  = MDU_CNT_W'(DIV_CYCLES);

  mdu_state_e             state_q, state_d;
  mdu_op_e                op_q, op_d;
  logic [MDU_CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]            hi_q, hi_d, lo_q, lo_d;
  logic [31:0]            a_q, a_d, b_q, b_d;

  logic [63:0]            prod_s, prod_u;
  logic [31:0]            quot_s, rem_s, quot_u, rem_u;
  logic                   div_ovf;

  // Results come only from the latched operands; a/b may change during RUN.
  assign prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u  = {32'd0, a_q} * {32'd0, b_q};
  assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign quot_u  = a_q / b_q;
  assign rem_u   = a_q % b_q;

  // -2^31 / -1 does not fit; MIPS leaves the wrapped quotient and no trap.
  always_comb begin
    quot_s = 32'd0;
    rem_s  = 32'd0;
    if (div_ovf) begin
      quot_s = 32'h8000_0000;
      rem_s  = 32'd0;
    end else begin
      quot_s = $signed(a_q) / $signed(b_q);
      rem_s  = $signed(a_q) % $signed(b_q);
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (mdu_op_e'(op))
            MDU_MULT, MDU_MULTU: begin
              state_d = ST_RUN;
              op_d    = mdu_op_e'(op);
              cnt_d   = MULT_N;
              a_d     = a;
              b_d     = b;
            end
            MDU_DIV, MDU_DIVU: begin
              state_d = ST_RUN;
              op_d    = mdu_op_e'(op);
              cnt_d   = DIV_N;
              a_d     = a;
              b_d     = b;
            end
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q == MDU_CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          case (op_q)
            MDU_MULT:  {hi_d, lo_d} = prod_s;
            MDU_MULTU: {hi_d, lo_d} = prod_u;
            // Divide by zero leaves HI/LO untouched but still costs the full latency.
            MDU_DIV: if (b_q != 32'd0) begin
              hi_d = rem_s;
              lo_d = quot_s;
            end
            MDU_DIVU: if (b_q != 32'd0) begin
              hi_d = rem_u;
              lo_d = quot_u;
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - MDU_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= MDU_NONE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed and randomized bench for mdu against an arithmetic reference model.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one operation, straight from the ISA rules.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int signed      sx, sy, q, r;
    longint signed  ps;
    logic [63:0]    pu;
    sx = x;
    sy = y;
    case (o)
      3'd1: begin
        ps   = longint'(sx) * longint'(sy);
        m_hi = ps[63:32];
        m_lo = ps[31:0];
      end
      3'd2: begin
        pu   = 64'(x) * 64'(y);
        m_hi = pu[63:32];
        m_lo = pu[31:0];
      end
      3'd3: if (y != 32'd0) begin
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'd0;
        end else begin
          q = sx / sy;
          r = sx % sy;
          m_lo = q;
          m_hi = r;
        end
      end
      3'd4: if (y != 32'd0) begin
        m_lo = x / y;
        m_hi = x % y;
      end
      3'd5: m_hi = x;
      3'd6: m_lo = x;
      default: ;
    endcase
  endtask

  // Called at a negedge; issues the op and returns at the first negedge with busy=0.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit disturb);
    int cyc;
    int n;
    logic [31:0] oh, ol;
    oh = m_hi;
    ol = m_lo;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    model(o, x, y);
    if (o == 3'd5 || o == 3'd6) begin
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_hi"}, hi, m_hi);
      chk({tag, "_lo"}, lo, m_lo);
      return;
    end
    n   = (o <= 3'd2) ? MC : DC;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      if (cyc == 0) begin
        chk({tag, "_hold_hi"}, hi, oh);
        chk({tag, "_hold_lo"}, lo, ol);
      end
      if (disturb && cyc == 1) begin
        start = 1'b1;
        op    = 3'd6;
        a     = 32'h55;
      end
      if (disturb && cyc == 2) start = 1'b0;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(cyc), 32'(n));
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;

    // Reset held with an MTHI strobe present.
    reset = 1'b0;
    start = 1'b1;
    op    = 3'd5;
    a     = 32'h1234;
    b     = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    run_op("mthi", 3'd5, 32'h0000_1234, 32'd0, 1'b0);
    chk("mthi_busy_after", 32'(busy), 32'd0);

    run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_neg_hi_k", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo_k", lo, 32'hFFFF_FFFA);

    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_hi_k", hi, 32'h0000_0001);
    chk("multu_lo_k", lo, 32'hFFFF_FFFE);

    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_neg_lo_k", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi_k", hi, 32'hFFFF_FFFF);

    run_op("pre_hi", 3'd5, 32'hAA, 32'd0, 1'b0);
    run_op("pre_lo", 3'd6, 32'hBB, 32'd0, 1'b0);
    run_op("divu_zero", 3'd4, 32'h1234_5678, 32'd0, 1'b0);
    chk("divu_zero_hi_k", hi, 32'hAA);
    chk("divu_zero_lo_k", lo, 32'hBB);

    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_lo_k", lo, 32'h8000_0000);
    chk("div_ovf_hi_k", hi, 32'd0);

    run_op("mult_mtlo", 3'd1, 32'h0000_0100, 32'h0000_0003, 1'b1);
    chk("mult_mtlo_lo_k", lo, 32'h0000_0300);

    // Reset during busy cycle 2 of a DIV.
    start = 1'b1;
    op    = 3'd3;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_late_busy", 32'(busy), 32'd0);
    chk("midrst_late_hi", hi, 32'd0);
    chk("midrst_late_lo", lo, 32'd0);

    // Randomized back-to-back traffic with boundary operands mixed in.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(1, 6));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: ry = 32'($urandom_range(1, 9));
        3: ry = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op("rand", ro, rx, ry, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the pipelined MIPS datapath, sitting directly downstream of the general register file. It consumes the two register read ports (rs on `a`, rt on `b`) and executes mult, multu, div, divu, mthi and mtlo against private HI/LO registers. Arithmetic takes a fixed multi-cycle latency, signalled on `busy` so the hazard unit can stall. `hi` and `lo` feed the mfhi/mflo path back into register write-back.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for mult/multu (legal range 1..15).
- `DIV_CYCLES`, 10: busy cycles for div/divu (legal range 1..15).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `start`  in  1  one-cycle strobe, qualifies `op`.
- `op`  in  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 reserved.
- `a`  in  32  rs operand (GRF RD1).
- `b`  in  32  rt operand (GRF RD2).
- `busy`  out  1  arithmetic in progress.
- `hi`  out  32  current HI register.
- `lo`  out  32  current LO register.

## Operation
- States: IDLE, RUN.
- IDLE:
  - `start` with MULT, MULTU, DIV or DIVU latches `a` and `b`, loads the counter with the op's cycle count, and goes to RUN.
  - `start` with MTHI writes `a` into HI on the same edge. MTLO does the same for LO. State stays IDLE.
  - NONE, the reserved code, or `start`=0: no effect.
- RUN:
  - Counter decrements every cycle.
  - On the edge where the counter is 1, the result is written to HI/LO and the state returns to IDLE.
  - `start` is ignored in RUN for every op, including MTHI/MTLO. The upstream must stall while `busy`=1.
- Arithmetic results:
  - MULT: {HI,LO} = signed 64-bit a×b.
  - MULTU: {HI,LO} = unsigned 64-bit a×b.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Operands are taken only from the latched copies. Changes on `a`/`b` during RUN have no effect.
- Division boundary cases:
  - Divide by zero (`b`=0): HI and LO keep their prior values. The full DIV_CYCLES busy period still occurs.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000, with no trap.
- `hi`/`lo` always show the architectural registers. They hold their old values throughout RUN.

## Timing
- Reset value of every output: `busy`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Reset asserted in the middle of RUN aborts the operation immediately. No result is written.
- Let the start edge be E0. Then:
  - `busy` is 1 from just after E0 until just after E(N), where N is the op's cycle count.
  - HI/LO update at edge E(N).
  - `busy` is 0 in the cycle following E(N).
  - Net effect: exactly N cycles of `busy`=1.
- Back-to-back operations: a `start` in the first cycle with `busy`=0 is accepted.
- MTHI/MTLO latency is 1 edge. `busy` is never raised for them.
- `busy` is registered and carries no combinational path from `start`. The hazard unit ORs `start` with `busy` for the stall condition itself.

## Structure
- Shared package `mdu_defs` holds:
  - op encodings MDU_NONE..MDU_MTLO;
  - state encodings ST_IDLE and ST_RUN;
  - the 4-bit counter width constant.
- The decoder and hazard unit import the same package.
- A single flat module. The products and quotients use inline `*`, `/` and `%` on the latched operands, with `$signed` for the signed ops.
- No sub-module is warranted.

## Test plan
- Reset clears state: hold `reset`=0 with a MTHI 0x1234 strobe asserted → `hi`=0, `lo`=0, `busy`=0.
  - Then release reset and issue MTHI 0x1234 → `hi`=0x00001234 one edge later, `busy` never 1.
- Signed multiply: MULT a=0xFFFFFFFE (−2), b=3 → `busy` high for exactly 5 cycles, then `hi`=0xFFFFFFFF and `lo`=0xFFFFFFFA.
- Unsigned multiply and operand latching: MULTU a=0xFFFFFFFF, b=2, then change `a` mid-run → `hi`=0x00000001 and `lo`=0xFFFFFFFE.
- Signed divide: DIV a=0xFFFFFFF9 (−7), b=2 → after 10 busy cycles `lo`=0xFFFFFFFD (−3) and `hi`=0xFFFFFFFF (−1).
- Divide-by-zero and overflow:
  - Preload HI=0xAA and LO=0xBB, then DIVU b=0 → 10 busy cycles, then `hi`=0xAA and `lo`=0xBB unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Ignored start and mid-run reset:
  - During a MULT, pulse MTLO a=0x55 → `lo` shows only the product.
  - Drive `reset`=0 in busy cycle 2 of a DIV → `busy`=0, `hi`=`lo`=0 immediately, and no later write occurs.
